// File: rtl/cond_unit.sv
// Conditional-execution stage: holds NZCV, evaluates the condition field,
// gates decoder strobes and keeps saturating executed/skipped counters.
module cond_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       cond,
    input  logic [3:0]       alu_flags,
    input  logic             pcs,
    input  logic             reg_w,
    input  logic             mem_w,
    input  logic             no_write,
    input  logic [1:0]       flag_w,
    input  logic             stall,
    output logic             pcsrc,
    output logic             reg_write,
    output logic             mem_write,
    output logic [3:0]       flags,
    output logic             carry_in,
    output logic             cond_ex,
    output logic [CNT_W-1:0] exec_count,
    output logic [CNT_W-1:0] skip_count
);

    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] exec_q, exec_d;
    logic [CNT_W-1:0] skip_q, skip_d;
    logic             flag_n, flag_z, flag_c, flag_v;

    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    // Condition check against the registered flags only (no ALU bypass).
    always_comb begin
        cond_ex = 1'b0;
        unique case (cond)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = ~flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = ~flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = ~flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = ~flag_v;
            4'b1000: cond_ex = flag_c & ~flag_z;
            4'b1001: cond_ex = ~flag_c | flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ex = flag_z | (flag_n != flag_v);
            4'b1110, 4'b1111: cond_ex = 1'b1;
        endcase
    end

    // Zero-latency gating of the decoder strobes.
    always_comb begin
        pcsrc     = pcs & cond_ex & ~stall;
        reg_write = reg_w & ~no_write & cond_ex & ~stall;
        mem_write = mem_w & cond_ex & ~stall;
    end

    // Next flags and counters; both halves of NZCV update independently.
    always_comb begin
        flags_d = flags_q;
        exec_d  = exec_q;
        skip_d  = skip_q;
        if (!stall) begin
            if (cond_ex) begin
                if (flag_w[1]) flags_d[3:2] = alu_flags[3:2];
                if (flag_w[0]) flags_d[1:0] = alu_flags[1:0];
                if (exec_q != {CNT_W{1'b1}}) exec_d = exec_q + CNT_W'(1);
            end else begin
                if (skip_q != {CNT_W{1'b1}}) skip_d = skip_q + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous active-low reset taking priority.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags_q <= 4'b0000;
            exec_q  <= '0;
            skip_q  <= '0;
        end else begin
            flags_q <= flags_d;
            exec_q  <= exec_d;
            skip_q  <= skip_d;
        end
    end

    assign flags      = flags_q;
    assign carry_in   = flags_q[1];
    assign exec_count = exec_q;
    assign skip_count = skip_q;

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit: vector table plus reset, condition sweep
// and counter-saturation sequences.
module tb_cond_unit;

    logic        clk;
    logic        reset_n;
    logic [3:0]  cond;
    logic [3:0]  alu_flags;
    logic        pcs, reg_w, mem_w, no_write, stall;
    logic [1:0]  flag_w;
    logic        pcsrc, reg_write, mem_write, carry_in, cond_ex;
    logic [3:0]  flags;
    logic [15:0] exec_count, skip_count;

    logic        s_pcsrc, s_reg_write, s_mem_write, s_carry_in, s_cond_ex;
    logic [3:0]  s_flags;
    logic [3:0]  s_exec_count, s_skip_count;

    int n_vec  = 0;
    int n_miss = 0;
    int exp_exec;
    int exp_skip;

    cond_unit #(.CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .cond(cond), .alu_flags(alu_flags),
        .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w), .no_write(no_write),
        .flag_w(flag_w), .stall(stall), .pcsrc(pcsrc), .reg_write(reg_write),
        .mem_write(mem_write), .flags(flags), .carry_in(carry_in),
        .cond_ex(cond_ex), .exec_count(exec_count), .skip_count(skip_count)
    );

    // Narrow instance sharing the same stimulus, used for saturation.
    cond_unit #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset_n(reset_n), .cond(cond), .alu_flags(alu_flags),
        .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w), .no_write(no_write),
        .flag_w(flag_w), .stall(stall), .pcsrc(s_pcsrc), .reg_write(s_reg_write),
        .mem_write(s_mem_write), .flags(s_flags), .carry_in(s_carry_in),
        .cond_ex(s_cond_ex), .exec_count(s_exec_count), .skip_count(s_skip_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cond;
        logic [3:0] alu;
        logic       pcs;
        logic       reg_w;
        logic       mem_w;
        logic       no_write;
        logic [1:0] flag_w;
        logic       stall;
        logic       e_cond_ex;
        logic       e_pcsrc;
        logic       e_reg_write;
        logic       e_mem_write;
        logic [3:0] e_flags;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Independent condition model: pairs of codes share a base term, odd code inverts.
    function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (c[3:1] == 3'd7) return 1'b1;
        return base ^ c[0];
    endfunction

    initial begin
        //          cond   alu     pcs   reg_w mem_w nowr  fw     stall  cex   pcsrc rw    mw    flags
        vecs[0]  = '{4'hE, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1100};
        vecs[1]  = '{4'hE, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1110};
        vecs[2]  = '{4'hE, 4'b1010, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1010};
        vecs[3]  = '{4'h0, 4'b0101, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010};
        vecs[4]  = '{4'hE, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110};
        vecs[5]  = '{4'hE, 4'b1001, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110};
        vecs[6]  = '{4'h4, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110};
        vecs[7]  = '{4'h0, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0101};
        vecs[8]  = '{4'h8, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0101};
        vecs[9]  = '{4'h9, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1001};
        vecs[10] = '{4'hA, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1001};
        vecs[11] = '{4'hB, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1001};
        vecs[12] = '{4'hC, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000};
        vecs[13] = '{4'hF, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000};

        // Reset held two cycles while the inputs try to write flags.
        reset_n = 1'b0; cond = 4'hE; alu_flags = 4'hF; flag_w = 2'b11; stall = 1'b0;
        pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0; no_write = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_flags", int'(flags), 0);
        chk("reset_carry", int'(carry_in), 0);
        chk("reset_exec", int'(exec_count), 0);
        chk("reset_skip", int'(skip_count), 0);

        @(negedge clk);
        reset_n = 1'b1; reg_w = 1'b1; flag_w = 2'b00;
        #1;
        chk("release_reg_write", int'(reg_write), 1);
        @(posedge clk);
        #1;
        exp_exec = 1;
        exp_skip = 0;
        chk("release_exec", int'(exec_count), exp_exec);

        foreach (vecs[i]) begin
            @(negedge clk);
            cond = vecs[i].cond; alu_flags = vecs[i].alu; pcs = vecs[i].pcs;
            reg_w = vecs[i].reg_w; mem_w = vecs[i].mem_w; no_write = vecs[i].no_write;
            flag_w = vecs[i].flag_w; stall = vecs[i].stall;
            #1;
            chk($sformatf("v%0d_cond_ex", i), int'(cond_ex), int'(vecs[i].e_cond_ex));
            chk($sformatf("v%0d_pcsrc", i), int'(pcsrc), int'(vecs[i].e_pcsrc));
            chk($sformatf("v%0d_reg_write", i), int'(reg_write), int'(vecs[i].e_reg_write));
            chk($sformatf("v%0d_mem_write", i), int'(mem_write), int'(vecs[i].e_mem_write));
            if (!vecs[i].stall) begin
                if (vecs[i].e_cond_ex) exp_exec++;
                else exp_skip++;
            end
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_flags", i), int'(flags), int'(vecs[i].e_flags));
            chk($sformatf("v%0d_carry_in", i), int'(carry_in), int'(vecs[i].e_flags[1]));
            chk($sformatf("v%0d_exec", i), int'(exec_count), exp_exec);
            chk($sformatf("v%0d_skip", i), int'(skip_count), exp_skip);
        end

        // Full condition table: preload each NZCV, then sweep codes while stalled.
        pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0; no_write = 1'b0;
        for (int f = 0; f < 16; f++) begin
            @(negedge clk);
            cond = 4'hE; flag_w = 2'b11; alu_flags = 4'(f); stall = 1'b0;
            exp_exec++;
            @(posedge clk);
            #1;
            chk($sformatf("preload_%0d", f), int'(flags), f);
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                cond = 4'(c); stall = 1'b1; alu_flags = ~4'(f);
                #1;
                chk($sformatf("cond_f%0d_c%0d", f, c), int'(cond_ex),
                    int'(model_cond(4'(c), 4'(f))));
            end
        end
        @(posedge clk);
        #1;
        chk("sweep_exec_hold", int'(exec_count), exp_exec);
        chk("sweep_skip_hold", int'(skip_count), exp_skip);
        chk("sweep_flags_hold", int'(flags), 15);

        // Saturation: narrow counter stops at 15, wide one keeps going.
        @(negedge clk);
        reset_n = 1'b0; stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1; cond = 4'hE; flag_w = 2'b00;
        repeat (20) @(posedge clk);
        #1;
        chk("sat_exec_narrow", int'(s_exec_count), 15);
        chk("sat_skip_narrow", int'(s_skip_count), 0);
        chk("sat_exec_wide", int'(exec_count), 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
